// File: rtl/uart_pkg.sv
// Shared definitions for the UART channel: parity encodings, serialiser
// state type and frame-length helper, shared by the TX and future RX blocks.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } tx_state_e;

    // Number of bit periods in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; full/empty/count come straight
// from the registered pointers, so they reflect the state before each edge.
module sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AFULL_LVL  = FIFO_DEPTH - 2,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [AW:0]       count
);

    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout        = mem_q[rd_ptr_q[AW-1:0]];
    assign count       = wr_ptr_q - rd_ptr_q;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign almost_full = (count >= (AW+1)'(AFULL_LVL));

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter fed by an internal FIFO; drains autonomously and frames each
// word with start, DATA_W data bits (LSB first), optional parity and stop bits.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int AFULL_LVL    = FIFO_DEPTH - 2
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             din,
    input  logic                          clr_err,
    output logic                          full,
    output logic                          almost_full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   data_count,
    output logic                          overflow_err,
    output logic                          busy,
    output logic                          tx_finish,
    output logic                          tx_serial_data
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W + 1);

    tx_state_e         state_q;
    logic [CNT_W-1:0]  baud_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic              tx_q;
    logic              busy_q;
    logic              finish_q;
    logic              overflow_q;

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_pop;
    logic              par_bit;
    logic              baud_last;

    assign fifo_pop  = (state_q == ST_IDLE) && !empty;
    assign par_bit   = (PARITY == PAR_ODD) ? ~(^fifo_dout) : ^fifo_dout;
    assign baud_last = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .AFULL_LVL  (AFULL_LVL)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst         (rst),
        .push        (wr_en),
        .pop         (fifo_pop),
        .din         (din),
        .dout        (fifo_dout),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (data_count)
    );

    // Overflow is judged against the registered full flag; a new overflow beats clr_err.
    always_ff @(posedge clk_in) begin
        if (rst)                  overflow_q <= 1'b0;
        else if (wr_en && full)   overflow_q <= 1'b1;
        else if (clr_err)         overflow_q <= 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            baud_q   <= baud_last ? '0 : baud_q + CNT_W'(1);
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        shift_q <= fifo_dout;
                        par_q   <= par_bit;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_q    <= 1'b0;
                    baud_q  <= '0;
                    state_q <= ST_START;
                end
                ST_START: begin
                    if (baud_last) begin
                        tx_q    <= shift_q[0];
                        bit_q   <= '0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            bit_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= par_q;
                                state_q <= ST_PAR;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                ST_PAR: begin
                    if (baud_last) begin
                        tx_q    <= 1'b1;
                        bit_q   <= '0;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Raise tx_finish one cycle early so the registered pulse lands on the last stop cycle.
                    if (bit_q == BIT_W'(STOP_BITS - 1) && baud_q == CNT_W'(CLKS_PER_BIT - 2))
                        finish_q <= 1'b1;
                    if (baud_last) begin
                        if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_serial_data = tx_q;
    assign busy           = busy_q;
    assign tx_finish      = finish_q;
    assign overflow_err   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench: two channels (even/1-stop and odd/2-stop), expected frames
// queued at push time and checked by a serial-line monitor per channel.
module tb_uart_tx_fifo_param;
    import uart_pkg::*;

    localparam int C = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       gap;
        logic       abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_a = 1'b0, clr_a = 1'b0, wr_b = 1'b0, clr_b = 1'b0;
    logic [7:0] din_a = '0, din_b = '0;
    logic       full_a, afull_a, empty_a, ovf_a, busy_a, fin_a, tx_a;
    logic       full_b, afull_b, empty_b, ovf_b, busy_b, fin_b, tx_b;
    logic [2:0] cnt_a, cnt_b;

    logic line_w [2];
    logic fin_w  [2];
    assign line_w[0] = tx_a;
    assign line_w[1] = tx_b;
    assign fin_w[0]  = fin_a;
    assign fin_w[1]  = fin_b;

    exp_t q0[$];
    exp_t q1[$];
    logic mon_busy [2] = '{1'b0, 1'b0};
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_param #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) dut_a (
        .clk_in(clk), .rst(rst), .wr_en(wr_a), .din(din_a), .clr_err(clr_a),
        .full(full_a), .almost_full(afull_a), .empty(empty_a), .data_count(cnt_a),
        .overflow_err(ovf_a), .busy(busy_a), .tx_finish(fin_a), .tx_serial_data(tx_a));

    uart_tx_fifo_param #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(2)) dut_b (
        .clk_in(clk), .rst(rst), .wr_en(wr_b), .din(din_b), .clr_err(clr_b),
        .full(full_b), .almost_full(afull_b), .empty(empty_b), .data_count(cnt_b),
        .overflow_err(ovf_b), .busy(busy_b), .tx_finish(fin_b), .tx_serial_data(tx_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    task automatic expect_frame(input int id, input logic [7:0] d, input logic p,
                                input logic gap, input logic abort);
        exp_t e;
        e = '{d: d, p: p, gap: gap, abort: abort};
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic monitor(input int id);
        exp_t       e;
        int         idle;
        int         nstop;
        logic [7:0] got;
        logic       par;
        bit         seen;
        nstop = (id == 0) ? 1 : 2;
        idle  = 0;
        forever begin
            @(negedge clk);
            if (line_w[id] !== 1'b0) begin
                idle++;
                continue;
            end
            if (qsize(id) == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame ch%0d (t=%0t)", id, $time);
                repeat (12 * C) @(negedge clk);
                idle = 0;
                continue;
            end
            mon_busy[id] = 1'b1;
            if (id == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            if (e.abort) begin
                seen = 1'b0;
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(negedge clk);
                    if (rst === 1'b1) seen = 1'b1;
                end
                check($sformatf("abort_reset_seen ch%0d", id), 32'(seen), 32'd1);
                idle = 0;
                mon_busy[id] = 1'b0;
                continue;
            end
            if (e.gap) check($sformatf("idle_gap ch%0d", id), idle, 2);
            @(negedge clk);
            check($sformatf("start_bit ch%0d", id), 32'(line_w[id]), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(negedge clk);
                got[i] = line_w[id];
            end
            repeat (C) @(negedge clk);
            par = line_w[id];
            for (int j = 0; j < nstop; j++) begin
                repeat (C) @(negedge clk);
                check($sformatf("stop_bit%0d ch%0d", j, id), 32'(line_w[id]), 32'd1);
            end
            repeat (C - 2) @(negedge clk);
            check($sformatf("tx_finish ch%0d", id), 32'(fin_w[id]), 32'd1);
            check($sformatf("data ch%0d", id), 32'(got), 32'(e.d));
            check($sformatf("parity ch%0d d=%0h", id, e.d), 32'(par), 32'(e.p));
            idle = 0;
            mon_busy[id] = 1'b0;
        end
    endtask

    initial fork
        monitor(0);
        monitor(1);
    join_none

    // Waits for a free slot, then pushes for exactly one edge.
    task automatic push_a(input logic [7:0] d);
        for (int k = 0; k < 400 && full_a; k++) @(negedge clk);
        wr_a  = 1'b1;
        din_a = d;
        @(negedge clk);
        wr_a  = 1'b0;
    endtask

    task automatic push_raw_a(input logic [7:0] d);
        wr_a  = 1'b1;
        din_a = d;
        @(negedge clk);
        wr_a  = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        wr_b  = 1'b1;
        din_b = d;
        @(negedge clk);
        wr_b  = 1'b0;
    endtask

    task automatic drain(input int id, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (qsize(id) == 0 && !mon_busy[id]) done = 1'b1;
        end
        check($sformatf("drain ch%0d", id), 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [7:0] w5 [12] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F,
                            8'h3F, 8'h7F, 8'hFE, 8'hC3, 8'h81, 8'h96};
    logic       p5 [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int budget;
        bit found;
        budget = 20 * frame_bits(8, 2, 2) * C;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset tx", 32'(tx_a), 32'd1);
        check("reset empty", 32'(empty_a), 32'd1);
        check("reset full", 32'(full_a), 32'd0);
        check("reset afull", 32'(afull_a), 32'd0);
        check("reset count", 32'(cnt_a), 32'd0);
        check("reset ovf", 32'(ovf_a), 32'd0);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset fin", 32'(fin_a), 32'd0);

        // Even parity, one stop bit: 0xA5 latency and framing.
        expect_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        push_a(8'hA5);
        check("t1 count after push", 32'(cnt_a), 32'd1);
        check("t1 line high N", 32'(tx_a), 32'd1);
        @(negedge clk);
        check("t1 popped empty", 32'(empty_a), 32'd1);
        check("t1 busy in load", 32'(busy_a), 32'd1);
        check("t1 line high N+1", 32'(tx_a), 32'd1);
        @(negedge clk);
        check("t1 line low N+2", 32'(tx_a), 32'd0);
        drain(0, budget);

        // Odd parity, two stop bits on the second channel.
        expect_frame(1, 8'h00, 1'b1, 1'b0, 1'b0);
        expect_frame(1, 8'hFF, 1'b1, 1'b1, 1'b0);
        expect_frame(1, 8'h01, 1'b0, 1'b1, 1'b0);
        push_b(8'h00);
        push_b(8'hFF);
        push_b(8'h01);
        drain(1, budget);

        // Consecutive pushes sent in order with a two-cycle gap.
        expect_frame(0, 8'h11, 1'b0, 1'b0, 1'b0);
        expect_frame(0, 8'h22, 1'b0, 1'b1, 1'b0);
        expect_frame(0, 8'h33, 1'b0, 1'b1, 1'b0);
        expect_frame(0, 8'h44, 1'b0, 1'b1, 1'b0);
        push_a(8'h11);
        push_a(8'h22);
        push_a(8'h33);
        push_a(8'h44);
        drain(0, budget);
        check("t3 empty after drain", 32'(empty_a), 32'd1);
        check("t3 idle after drain", 32'(busy_a), 32'd0);

        // Overflow while the serialiser is busy with a frame.
        expect_frame(0, 8'h01, 1'b1, 1'b0, 1'b0);
        push_a(8'h01);
        repeat (3) @(negedge clk);
        expect_frame(0, 8'h07, 1'b1, 1'b1, 1'b0);
        expect_frame(0, 8'h0F, 1'b0, 1'b1, 1'b0);
        expect_frame(0, 8'h80, 1'b1, 1'b1, 1'b0);
        expect_frame(0, 8'hFE, 1'b1, 1'b1, 1'b0);
        push_raw_a(8'h07);
        push_raw_a(8'h0F);
        push_raw_a(8'h80);
        push_raw_a(8'hFE);
        check("t4 full", 32'(full_a), 32'd1);
        check("t4 count 4", 32'(cnt_a), 32'd4);
        check("t4 afull", 32'(afull_a), 32'd1);
        check("t4 no ovf yet", 32'(ovf_a), 32'd0);
        push_raw_a(8'h55);
        check("t4 ovf set", 32'(ovf_a), 32'd1);
        check("t4 count held", 32'(cnt_a), 32'd4);
        push_raw_a(8'hAA);
        repeat (5) @(negedge clk);
        check("t4 ovf sticky", 32'(ovf_a), 32'd1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("t4 ovf cleared", 32'(ovf_a), 32'd0);
        drain(0, budget);

        // Simultaneous push/pop at count 2, then enough traffic to wrap pointers.
        for (int i = 0; i < 12; i++) expect_frame(0, w5[i], p5[i], (i != 0), 1'b0);
        push_a(w5[0]);
        push_a(w5[1]);
        push_a(w5[2]);
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (!busy_a && !empty_a) found = 1'b1;
        end
        check("t5 idle with data", 32'(found), 32'd1);
        check("t5 count before", 32'(cnt_a), 32'd2);
        push_raw_a(w5[3]);
        check("t5 count push+pop", 32'(cnt_a), 32'd2);
        for (int i = 4; i < 12; i++) push_a(w5[i]);
        drain(0, budget);

        // Reset during data bit 3 of 0x5A with two words queued behind it.
        expect_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        push_a(8'h5A);
        push_a(8'h12);
        push_a(8'h34);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (tx_a === 1'b0) found = 1'b1;
            else @(negedge clk);
        end
        check("t6 start seen", 32'(found), 32'd1);
        repeat (17) @(negedge clk);
        check("t6 data bit3", 32'(tx_a), 32'd1);
        check("t6 queued 2", 32'(cnt_a), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6 line high", 32'(tx_a), 32'd1);
        check("t6 empty", 32'(empty_a), 32'd1);
        check("t6 count 0", 32'(cnt_a), 32'd0);
        check("t6 busy 0", 32'(busy_a), 32'd0);
        repeat (150) @(negedge clk);
        check("t6 still empty", 32'(empty_a), 32'd1);
        check("t6 scoreboard clear", qsize(0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
